// File: rtl/apu_issue_queue.sv
// ---------------------------------------------------------------------------
// apu_issue_queue
//
// Request buffer sitting between the core's APU master port and the vector
// accelerator's APU slave port. Offloaded instructions (three operands,
// opcode, flags) are queued in order, issued to the accelerator one per
// grant, and the number of issued-but-unanswered instructions is tracked so
// the accelerator never sees more than MAX_OUTSTANDING requests in flight.
// Results come back to the core through a single registered stage.
//
// Parameters
//   DEPTH            request FIFO entries (power of two, >= 2)
//   MAX_OUTSTANDING  issued instructions allowed without a returned rvalid (1..7)
//
// Ports
//   clk, reset       single rising-edge clock, synchronous active-high reset
//   apu_req_i        core request valid
//   apu_gnt_o        core request accepted when high together with apu_req_i
//   apu_operands_i   request operands, packed [2:0][31:0]
//   apu_op_i         request opcode
//   apu_flags_i      request flags
//   apu_rvalid_o     result valid to core, one-cycle pulse per result
//   apu_result_o     result to core, held while apu_rvalid_o is low
//   acc_req_o        request valid to accelerator
//   acc_gnt_i        accelerator accepts the head entry
//   acc_operands_o   head entry operands (zero when empty)
//   acc_op_o         head entry opcode   (zero when empty)
//   acc_flags_o      head entry flags    (zero when empty)
//   acc_rvalid_i     accelerator result valid
//   acc_result_i     accelerator result
//   count_o          occupied FIFO entries
//   inflight_o       issued, unanswered instructions
//   busy_o           anything queued or in flight
//   err_o            sticky: a result arrived with nothing in flight
// ---------------------------------------------------------------------------
module apu_issue_queue #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic                         apu_req_i,
  output logic                         apu_gnt_o,
  input  logic [2:0][31:0]             apu_operands_i,
  input  logic [5:0]                   apu_op_i,
  input  logic [14:0]                  apu_flags_i,
  output logic                         apu_rvalid_o,
  output logic [31:0]                  apu_result_o,

  output logic                         acc_req_o,
  input  logic                         acc_gnt_i,
  output logic [2:0][31:0]             acc_operands_o,
  output logic [5:0]                   acc_op_o,
  output logic [14:0]                  acc_flags_o,
  input  logic                         acc_rvalid_i,
  input  logic [31:0]                  acc_result_i,

  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [2:0]                   inflight_o,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [2:0]       MAX_OUT_C = 3'(MAX_OUTSTANDING);

  // One 117-bit queue entry: {operands, op, flags}.
  typedef struct packed {
    logic [2:0][31:0] operands;
    logic [5:0]       op;
    logic [14:0]      flags;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [2:0]        inflight;
  logic              err;
  logic              rvalid_q;
  logic [31:0]       result_q;

  logic              push;
  logic              pop;
  logic              rsp_matched;

  // Handshake decisions. The core grant depends only on occupancy so the
  // core can see it without a combinational path from apu_req_i. Issue is
  // throttled by the outstanding limit so the accelerator is never flooded.
  // A response only counts against inflight if something was actually in
  // flight; otherwise it is spurious and only raises err.
  always_comb begin
    apu_gnt_o   = (count < DEPTH_C);
    acc_req_o   = (count != '0) && (inflight < MAX_OUT_C);
    push        = apu_req_i && apu_gnt_o;
    pop         = acc_req_o && acc_gnt_i;
    rsp_matched = acc_rvalid_i && (inflight != 3'd0);
  end

  // Queue storage. Entries need no reset because the payload outputs are
  // masked to zero whenever the queue is empty, so stale contents never leak.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{operands: apu_operands_i, op: apu_op_i, flags: apu_flags_i};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. Occupancy is a
  // separate counter so that full and empty are unambiguous when the
  // pointers are equal; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Outstanding-request tracking. An issue and a matched response in the
  // same cycle cancel out. A spurious response never drives the count below
  // zero; it latches the sticky error instead, which only reset clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= 3'd0;
      err      <= 1'b0;
    end else begin
      if (pop && !rsp_matched) begin
        inflight <= inflight + 3'd1;
      end else if (!pop && rsp_matched) begin
        inflight <= inflight - 3'd1;
      end
      if (acc_rvalid_i && (inflight == 3'd0)) begin
        err <= 1'b1;
      end
    end
  end

  // Result return stage. Every accelerator response is forwarded one cycle
  // later, including spurious ones, and the result register holds its last
  // value between pulses. Responses seen while in reset are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      result_q <= '0;
    end else begin
      rvalid_q <= acc_rvalid_i;
      if (acc_rvalid_i) begin
        result_q <= acc_result_i;
      end
    end
  end

  // Head-of-queue payload. Because the head only moves on a grant, the
  // payload stays stable for as long as acc_req_o is held waiting.
  always_comb begin
    head = '0;
    if (count != '0) begin
      head = mem[rd_ptr];
    end
  end

  assign acc_operands_o = head.operands;
  assign acc_op_o       = head.op;
  assign acc_flags_o    = head.flags;

  assign apu_rvalid_o   = rvalid_q;
  assign apu_result_o   = result_q;
  assign count_o        = count;
  assign inflight_o     = inflight;
  assign busy_o         = (count != '0) || (inflight != 3'd0);
  assign err_o          = err;

endmodule

// File: tb/tb_apu_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_apu_issue_queue
//
// Self-checking bench for apu_issue_queue (DEPTH=4, MAX_OUTSTANDING=2).
// A queue-based reference model tracks what the block should hold, how many
// instructions are in flight, the sticky error and the registered result.
// Directed scenarios are followed by a randomized run compared every cycle.
// ---------------------------------------------------------------------------
module tb_apu_issue_queue;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;
  localparam int CNT_W   = $clog2(DEPTH+1);

  logic                clk;
  logic                reset;
  logic                apu_req_i;
  logic                apu_gnt_o;
  logic [2:0][31:0]    apu_operands_i;
  logic [5:0]          apu_op_i;
  logic [14:0]         apu_flags_i;
  logic                apu_rvalid_o;
  logic [31:0]         apu_result_o;
  logic                acc_req_o;
  logic                acc_gnt_i;
  logic [2:0][31:0]    acc_operands_o;
  logic [5:0]          acc_op_o;
  logic [14:0]         acc_flags_o;
  logic                acc_rvalid_i;
  logic [31:0]         acc_result_i;
  logic [CNT_W-1:0]    count_o;
  logic [2:0]          inflight_o;
  logic                busy_o;
  logic                err_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [116:0] mq[$];
  int           m_inflight;
  bit           m_err;
  bit           m_rvalid;
  logic [31:0]  m_result;

  apu_issue_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .apu_req_i      (apu_req_i),
    .apu_gnt_o      (apu_gnt_o),
    .apu_operands_i (apu_operands_i),
    .apu_op_i       (apu_op_i),
    .apu_flags_i    (apu_flags_i),
    .apu_rvalid_o   (apu_rvalid_o),
    .apu_result_o   (apu_result_o),
    .acc_req_o      (acc_req_o),
    .acc_gnt_i      (acc_gnt_i),
    .acc_operands_o (acc_operands_o),
    .acc_op_o       (acc_op_o),
    .acc_flags_o    (acc_flags_o),
    .acc_rvalid_i   (acc_rvalid_i),
    .acc_result_i   (acc_result_i),
    .count_o        (count_o),
    .inflight_o     (inflight_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance the reference model by one clock using the currently driven inputs.
  task automatic model_step();
    bit push, pop, rv;
    if (reset) begin
      mq.delete();
      m_inflight = 0;
      m_err      = 1'b0;
      m_rvalid   = 1'b0;
      m_result   = '0;
    end else begin
      push = apu_req_i && (mq.size() < DEPTH);
      pop  = acc_gnt_i && (mq.size() != 0) && (m_inflight < MAX_OUT);
      rv   = acc_rvalid_i;
      if (rv && m_inflight == 0) m_err = 1'b1;
      m_inflight = m_inflight + (pop ? 1 : 0) - ((rv && m_inflight > 0) ? 1 : 0);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({apu_operands_i, apu_op_i, apu_flags_i});
      m_rvalid = rv;
      if (rv) m_result = acc_result_i;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    apu_req_i      = 1'b0;
    apu_operands_i = '0;
    apu_op_i       = '0;
    apu_flags_i    = '0;
    acc_gnt_i      = 1'b0;
    acc_rvalid_i   = 1'b0;
    acc_result_i   = '0;
  endtask

  task automatic drive_random_req(input logic [5:0] op);
    apu_req_i      = 1'b1;
    apu_operands_i = {$urandom, $urandom, $urandom};
    apu_op_i       = op;
    apu_flags_i    = 15'($urandom);
  endtask

  // Grant and answer until the model reports nothing queued or in flight.
  task automatic drain();
    int cyc = 0;
    idle_inputs();
    while ((mq.size() != 0 || m_inflight != 0) && cyc < 50) begin
      acc_gnt_i    = 1'b1;
      acc_rvalid_i = (m_inflight > 0);
      acc_result_i = $urandom;
      tick();
      cyc++;
    end
    idle_inputs();
    tick();
    tests_run++;
    if (cyc >= 50) begin
      tests_failed++;
      $display("[TB] FAIL drain_timeout: count=%0d inflight=%0d, required empty", count_o, inflight_o);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests_run++;
    if (apu_gnt_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_gnt: got %b want 1", apu_gnt_o); end
    tests_run++;
    if (acc_req_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_acc_req: got %b want 0", acc_req_o); end
    tests_run++;
    if ({acc_operands_o, acc_op_o, acc_flags_o} !== 117'd0) begin
      tests_failed++; $display("[TB] FAIL reset_payload: got %h want 0", {acc_operands_o, acc_op_o, acc_flags_o});
    end
    tests_run++;
    if ({apu_rvalid_o, apu_result_o} !== 33'd0) begin
      tests_failed++; $display("[TB] FAIL reset_result: got %b/%h want 0/0", apu_rvalid_o, apu_result_o);
    end
    tests_run++;
    if ({count_o, inflight_o, busy_o, err_o} !== '0) begin
      tests_failed++; $display("[TB] FAIL reset_status: count=%0d inflight=%0d busy=%b err=%b want all 0",
                               count_o, inflight_o, busy_o, err_o);
    end
  endtask

  task automatic test_single_op();
    logic [116:0] exp_entry;
    idle_inputs();
    apu_req_i      = 1'b1;
    apu_operands_i = {32'd1, 32'd2, 32'd3};
    apu_op_i       = 6'h05;
    apu_flags_i    = 15'h0;
    exp_entry      = {96'({32'd1, 32'd2, 32'd3}), 6'h05, 15'h0};
    tests_run++;
    if (acc_req_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_no_bypass: acc_req got %b want 0", acc_req_o); end
    tick();
    idle_inputs();
    tests_run++;
    if (acc_req_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_acc_req: got %b want 1", acc_req_o); end
    tests_run++;
    if ({acc_operands_o, acc_op_o, acc_flags_o} !== exp_entry) begin
      tests_failed++; $display("[TB] FAIL single_payload: got %h want %h", {acc_operands_o, acc_op_o, acc_flags_o}, exp_entry);
    end
    acc_gnt_i = 1'b1;
    tick();
    idle_inputs();
    tick();
    acc_rvalid_i = 1'b1;
    acc_result_i = 32'h1F;
    tick();
    idle_inputs();
    tests_run++;
    if (apu_rvalid_o !== 1'b1 || apu_result_o !== 32'h1F) begin
      tests_failed++; $display("[TB] FAIL single_result: got %b/%h want 1/0000001f", apu_rvalid_o, apu_result_o);
    end
    tick();
    tests_run++;
    if (apu_rvalid_o !== 1'b0 || apu_result_o !== 32'h1F || busy_o !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL single_after: rvalid=%b result=%h busy=%b want 0/0000001f/0",
                               apu_rvalid_o, apu_result_o, busy_o);
    end
  endtask

  task automatic test_fill();
    int pops = 0;
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      drive_random_req(6'(i));
      tests_run++;
      if (apu_gnt_o !== (i < DEPTH)) begin
        tests_failed++; $display("[TB] FAIL fill_gnt[%0d]: got %b want %b", i, apu_gnt_o, (i < DEPTH));
      end
      tick();
    end
    idle_inputs();
    tests_run++;
    if (count_o !== CNT_W'(DEPTH)) begin tests_failed++; $display("[TB] FAIL fill_count: got %0d want %0d", count_o, DEPTH); end
    for (int c = 0; c < 12; c++) begin
      acc_gnt_i    = 1'b1;
      acc_rvalid_i = (m_inflight > 0);
      acc_result_i = $urandom;
      if (acc_req_o) begin
        tests_run++;
        if (acc_op_o !== 6'(pops)) begin
          tests_failed++; $display("[TB] FAIL fill_order[%0d]: got op %0d want %0d", pops, acc_op_o, pops);
        end
        pops++;
      end
      tick();
    end
    tests_run++;
    if (pops != DEPTH) begin tests_failed++; $display("[TB] FAIL fill_pops: got %0d want %0d", pops, DEPTH); end
    drain();
  endtask

  task automatic test_wrap();
    logic [116:0] pushed[$];
    int pop_idx = 0;
    idle_inputs();
    for (int c = 0; c < 10; c++) begin
      drive_random_req(6'($urandom));
      pushed.push_back({apu_operands_i, apu_op_i, apu_flags_i});
      acc_gnt_i    = 1'b1;
      acc_rvalid_i = (m_inflight > 0);
      acc_result_i = $urandom;
      if (c > 0) begin
        tests_run++;
        if (acc_req_o !== 1'b1 || {acc_operands_o, acc_op_o, acc_flags_o} !== pushed[pop_idx]) begin
          tests_failed++; $display("[TB] FAIL wrap_payload[%0d]: req=%b got %h want %h", pop_idx, acc_req_o,
                                   {acc_operands_o, acc_op_o, acc_flags_o}, pushed[pop_idx]);
        end
        pop_idx++;
      end
      tick();
      tests_run++;
      if (count_o !== CNT_W'(1)) begin tests_failed++; $display("[TB] FAIL wrap_count[%0d]: got %0d want 1", c, count_o); end
    end
    drain();
  endtask

  task automatic test_outstanding();
    int grants = 0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      drive_random_req(6'(i + 8));
      tick();
    end
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      acc_gnt_i = 1'b1;
      if (acc_req_o) grants++;
      tick();
    end
    tests_run++;
    if (grants != MAX_OUT) begin tests_failed++; $display("[TB] FAIL limit_grants: got %0d want %0d", grants, MAX_OUT); end
    tests_run++;
    if (acc_req_o !== 1'b0 || inflight_o !== 3'(MAX_OUT)) begin
      tests_failed++; $display("[TB] FAIL limit_hold: req=%b inflight=%0d want 0/%0d", acc_req_o, inflight_o, MAX_OUT);
    end
    acc_rvalid_i = 1'b1;
    acc_result_i = 32'h1234;
    tick();
    acc_rvalid_i = 1'b0;
    tests_run++;
    if (acc_req_o !== 1'b1 || inflight_o !== 3'(MAX_OUT - 1)) begin
      tests_failed++; $display("[TB] FAIL limit_release: req=%b inflight=%0d want 1/%0d", acc_req_o, inflight_o, MAX_OUT - 1);
    end
    drain();
  endtask

  task automatic test_random();
    logic [116:0] exp_payload;
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      exp_payload = (mq.size() != 0) ? mq[0] : 117'd0;
      tests_run++;
      if (apu_gnt_o !== (mq.size() < DEPTH) || acc_req_o !== (mq.size() != 0 && m_inflight < MAX_OUT)) begin
        tests_failed++; $display("[TB] FAIL rand_handshake[%0d]: gnt=%b req=%b model size=%0d inflight=%0d",
                                 c, apu_gnt_o, acc_req_o, mq.size(), m_inflight);
      end
      tests_run++;
      if ({acc_operands_o, acc_op_o, acc_flags_o} !== exp_payload) begin
        tests_failed++; $display("[TB] FAIL rand_payload[%0d]: got %h want %h", c, {acc_operands_o, acc_op_o, acc_flags_o}, exp_payload);
      end
      tests_run++;
      if (count_o !== CNT_W'(mq.size()) || inflight_o !== 3'(m_inflight) ||
          busy_o !== (mq.size() != 0 || m_inflight != 0) || err_o !== m_err) begin
        tests_failed++; $display("[TB] FAIL rand_status[%0d]: count=%0d/%0d inflight=%0d/%0d busy=%b err=%b/%b",
                                 c, count_o, mq.size(), inflight_o, m_inflight, busy_o, err_o, m_err);
      end
      tests_run++;
      if (apu_rvalid_o !== m_rvalid || apu_result_o !== m_result) begin
        tests_failed++; $display("[TB] FAIL rand_result[%0d]: got %b/%h want %b/%h", c, apu_rvalid_o, apu_result_o, m_rvalid, m_result);
      end
      if ($urandom_range(9) < 6) drive_random_req(6'($urandom));
      else apu_req_i = 1'b0;
      acc_gnt_i    = ($urandom_range(9) < 6);
      acc_rvalid_i = (m_inflight > 0) && ($urandom_range(9) < 5);
      acc_result_i = $urandom;
      tick();
    end
    drain();
  endtask

  task automatic test_spurious();
    idle_inputs();
    acc_rvalid_i = 1'b1;
    acc_result_i = 32'hABCD;
    tick();
    idle_inputs();
    tests_run++;
    if (err_o !== 1'b1 || apu_rvalid_o !== 1'b1 || apu_result_o !== 32'hABCD || inflight_o !== 3'd0) begin
      tests_failed++; $display("[TB] FAIL spurious: err=%b rvalid=%b result=%h inflight=%0d want 1/1/0000abcd/0",
                               err_o, apu_rvalid_o, apu_result_o, inflight_o);
    end
    tick();
    tick();
    tests_run++;
    if (err_o !== 1'b1 || apu_rvalid_o !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL spurious_sticky: err=%b rvalid=%b want 1/0", err_o, apu_rvalid_o);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      drive_random_req(6'(i + 20));
      tick();
    end
    idle_inputs();
    acc_gnt_i = 1'b1;
    tick();
    idle_inputs();
    tests_run++;
    if (count_o !== CNT_W'(3) || inflight_o !== 3'd1) begin
      tests_failed++; $display("[TB] FAIL mid_setup: count=%0d inflight=%0d want 3/1", count_o, inflight_o);
    end
    reset        = 1'b1;
    acc_rvalid_i = 1'b1;
    acc_result_i = 32'hDEAD;
    tick();
    reset = 1'b0;
    idle_inputs();
    tests_run++;
    if (apu_gnt_o !== 1'b1 || acc_req_o !== 1'b0 || {acc_operands_o, acc_op_o, acc_flags_o} !== 117'd0 ||
        apu_rvalid_o !== 1'b0 || apu_result_o !== 32'd0 || count_o !== '0 || inflight_o !== 3'd0 ||
        busy_o !== 1'b0 || err_o !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL mid_reset: gnt=%b req=%b rvalid=%b result=%h count=%0d inflight=%0d busy=%b err=%b",
                               apu_gnt_o, acc_req_o, apu_rvalid_o, apu_result_o, count_o, inflight_o, busy_o, err_o);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (apu_rvalid_o !== 1'b0 || acc_req_o !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL mid_quiet[%0d]: rvalid=%b req=%b want 0/0", c, apu_rvalid_o, acc_req_o);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_op();
    test_fill();
    test_wrap();
    test_outstanding();
    test_random();
    test_spurious();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/apu_issue_queue.md
# apu_issue_queue

Request buffer between the core's APU master port and the vector accelerator's APU slave port. It decouples the core's `apu_req`/`apu_gnt` handshake from accelerator stalls by holding up to DEPTH offloaded instructions (operands, opcode, flags) in order. It issues them to the accelerator one per grant, tracks how many issued instructions are still awaiting `apu_rvalid`, and returns results to the core through a registered stage. Instantiated in the core-side wrapper immediately upstream of `accelerator_top`.

## Interface
- DEPTH, 4, request FIFO entries; power of two, ≥2
- MAX_OUTSTANDING, 2, max instructions issued to the accelerator without a returned rvalid; 1..7
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- apu_req_i  in  1  core request valid
- apu_gnt_o  out  1  core request accepted this cycle when high together with apu_req_i
- apu_operands_i  in  3x32  packed `[2:0][31:0]` operands
- apu_op_i  in  6  APU opcode
- apu_flags_i  in  15  APU flags
- apu_rvalid_o  out  1  result valid to core, one-cycle pulse per result
- apu_result_o  out  32  result to core
- acc_req_o  out  1  request valid to accelerator
- acc_gnt_i  in  1  accelerator accepts the head entry
- acc_operands_o  out  3x32  head entry operands
- acc_op_o  out  6  head entry opcode
- acc_flags_o  out  15  head entry flags
- acc_rvalid_i  in  1  accelerator result valid
- acc_result_i  in  32  accelerator result
- count_o  out  $clog2(DEPTH+1)  occupied FIFO entries
- inflight_o  out  3  issued, unanswered instructions
- busy_o  out  1  count_o≠0 or inflight_o≠0
- err_o  out  1  sticky: acc_rvalid_i received with inflight_o==0

## Operation
- Storage: DEPTH x 117-bit entries {operands, op, flags}. Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is held in a separate counter.
- Push: apu_gnt_o = (count < DEPTH), a function of state only and independent of apu_req_i. When apu_req_i && apu_gnt_o, the entry is written at the write pointer and the pointer advances.
- Pop: acc_req_o = (count ≠ 0) && (inflight < MAX_OUTSTANDING). acc_* payload always shows the head entry, or zeros when empty. When acc_req_o && acc_gnt_i, the read pointer advances and inflight increments.
- No bypass: a push into an empty FIFO is visible on acc_req_o the next cycle.
- Push and pop in the same cycle: count unchanged. This is legal at any non-empty count, including count==DEPTH-1. At count==DEPTH no push occurs because gnt is low.
- Inflight bookkeeping:
  - acc_rvalid_i decrements inflight.
  - Issue and rvalid in the same cycle leave inflight unchanged.
  - acc_rvalid_i with inflight==0: inflight stays 0, err_o sets, and the result is still forwarded.
- Results: apu_rvalid_o <= acc_rvalid_i and apu_result_o <= acc_result_i. apu_result_o holds its value when rvalid is low. Order is preserved because the accelerator responds in issue order.
- err_o clears only on reset.

## Timing
- Reset values:
  - apu_gnt_o=1 (empty)
  - acc_req_o=0
  - acc_* payload=0
  - apu_rvalid_o=0
  - apu_result_o=0
  - count_o=0
  - inflight_o=0
  - busy_o=0
  - err_o=0
- Reset mid-operation discards all FIFO entries and in-flight tracking. Any acc_rvalid_i sampled during reset is dropped.
- Latency:
  - core accept at cycle N → acc_req_o high at N+1 at the earliest.
  - acc_rvalid_i at cycle M → apu_rvalid_o at M+1.
- Full throughput: one push and one pop per cycle sustained when the accelerator grants every cycle and inflight stays below MAX_OUTSTANDING.
- Once acc_req_o is high, the payload is stable until granted. The only exception is reset.
- Outstanding limit: with inflight==MAX_OUTSTANDING, acc_req_o is low. It rises in the cycle after the acc_rvalid_i that drops inflight.

## Test plan
- Single op: push op=0x05 with operands {1,2,3}. Expect acc_req_o one cycle later with the same payload. Grant; acc_rvalid_i with result 0x1F two cycles later. Expect apu_rvalid_o=1 with apu_result_o=0x1F one cycle after that, and busy_o=0 afterwards.
- Fill: hold acc_gnt_i=0 and push 5 requests (DEPTH=4). Expect count_o=4, apu_gnt_o=0 on the 5th request, and the 5th not stored. Then grant continuously. Expect ops popped in order 0..3 with no duplicates.
- Wrap and simultaneous: push and grant every cycle for 10 cycles with acc_rvalid_i returned one cycle after each grant. Expect count_o to stay at 1 and payload order to match push order across pointer wrap.
- Outstanding limit: MAX_OUTSTANDING=2, 3 entries queued, no rvalid. Expect exactly 2 grants, then acc_req_o=0 with inflight_o=2. One acc_rvalid_i → acc_req_o=1 on the next cycle.
- Spurious rvalid: acc_rvalid_i with inflight_o=0 → err_o=1 and sticky, apu_rvalid_o forwarded, inflight_o stays 0.
- Reset mid-operation: 3 entries queued and inflight=1, assert reset for one cycle. Expect all outputs at reset values on the following cycle, and no apu_rvalid_o for the discarded work.
